// File: rtl/mips_mem_pkg.sv
// Shared definitions for the memory-port scheduler and the address/wdata mux select.
package mips_mem_pkg;

   localparam int unsigned CNT_W = 4;

   localparam logic PORT_IF = 1'b0;
   localparam logic PORT_DM = 1'b1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_e;

endpackage

// File: rtl/mem_port_sched_if.sv
// Requester and memory-side signals of the shared memory port.
interface mem_port_sched_if #(
   parameter int unsigned DATA_W = 32
);
   logic              if_req;
   logic [DATA_W-1:0] if_rdata;
   logic              if_done;
   logic              dm_req;
   logic              dm_we;
   logic [DATA_W-1:0] dm_rdata;
   logic              dm_done;
   logic              mem_sel;
   logic              mem_en;
   logic              mem_we;
   logic [DATA_W-1:0] mem_rdata;

   // Scheduler side
   modport master (
      input  if_req, dm_req, dm_we, mem_rdata,
      output if_rdata, if_done, dm_rdata, dm_done, mem_sel, mem_en, mem_we
   );

   // Requesters plus memory
   modport slave (
      output if_req, dm_req, dm_we, mem_rdata,
      input  if_rdata, if_done, dm_rdata, dm_done, mem_sel, mem_en, mem_we
   );
endinterface

// File: rtl/mem_rr_pick2.sv
// Combinational two-way round-robin pick; mask[0] hides IF, mask[1] hides DM.
module mem_rr_pick2
   import mips_mem_pkg::*;
(
   input  logic       if_req,
   input  logic       dm_req,
   input  logic [1:0] mask,
   input  logic       last_grant,
   output logic       valid,
   output logic       winner
);
   logic if_v;
   logic dm_v;

   assign if_v   = if_req & ~mask[0];
   assign dm_v   = dm_req & ~mask[1];
   assign valid  = if_v | dm_v;
   // On a tie the port that was not granted last wins
   assign winner = (if_v & dm_v) ? ~last_grant : (dm_v ? PORT_DM : PORT_IF);
endmodule

// File: rtl/mem_port_sched.sv
// Round-robin scheduler for the single memory port shared by instruction fetch and data access.
module mem_port_sched
   import mips_mem_pkg::*;
#(
   parameter int unsigned MEM_LAT = 2,
   parameter int unsigned DATA_W  = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   mem_port_sched_if.master bus
);
   state_e            state_q, state_nx;
   logic [CNT_W-1:0]  cnt_q, cnt_nx;
   logic              last_q, last_nx;
   logic              sel_q, sel_nx;
   logic              en_q, en_nx;
   logic              we_q, we_nx;
   logic              if_done_q, if_done_nx;
   logic              dm_done_q, dm_done_nx;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_nx;
   logic [DATA_W-1:0] dm_rdata_q, dm_rdata_nx;

   logic [1:0]        pick_mask;
   logic              pick_valid;
   logic              pick_winner;

   // In RESP the finishing port still holds its request, so hide it
   assign pick_mask = (state_q == RESP) ? ((sel_q == PORT_DM) ? 2'b10 : 2'b01) : 2'b00;

   mem_rr_pick2 u_pick (
      .if_req     (bus.if_req),
      .dm_req     (bus.dm_req),
      .mask       (pick_mask),
      .last_grant (last_q),
      .valid      (pick_valid),
      .winner     (pick_winner)
   );

   always_comb begin
      state_nx    = state_q;
      cnt_nx      = cnt_q;
      last_nx     = last_q;
      sel_nx      = sel_q;
      en_nx       = 1'b0;
      we_nx       = 1'b0;
      if_done_nx  = 1'b0;
      dm_done_nx  = 1'b0;
      if_rdata_nx = if_rdata_q;
      dm_rdata_nx = dm_rdata_q;

      case (state_q)
         IDLE, RESP: begin
            if (pick_valid) begin
               state_nx = ACCESS;
               sel_nx   = pick_winner;
               cnt_nx   = CNT_W'(MEM_LAT);
               en_nx    = 1'b1;
               we_nx    = (pick_winner == PORT_DM) & bus.dm_we;
            end else begin
               state_nx = IDLE;
            end
         end
         ACCESS: begin
            // Counter at zero marks the cycle mem_rdata is valid
            if (cnt_q == '0) begin
               state_nx = RESP;
               last_nx  = sel_q;
               if (sel_q == PORT_DM) begin
                  dm_done_nx = 1'b1;
                  if (!bus.dm_we) dm_rdata_nx = bus.mem_rdata;
               end else begin
                  if_done_nx  = 1'b1;
                  if_rdata_nx = bus.mem_rdata;
               end
            end else begin
               cnt_nx = cnt_q - CNT_W'(1);
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         last_q     <= PORT_DM;
         sel_q      <= PORT_IF;
         en_q       <= 1'b0;
         we_q       <= 1'b0;
         if_done_q  <= 1'b0;
         dm_done_q  <= 1'b0;
         if_rdata_q <= '0;
         dm_rdata_q <= '0;
      end else begin
         state_q    <= state_nx;
         cnt_q      <= cnt_nx;
         last_q     <= last_nx;
         sel_q      <= sel_nx;
         en_q       <= en_nx;
         we_q       <= we_nx;
         if_done_q  <= if_done_nx;
         dm_done_q  <= dm_done_nx;
         if_rdata_q <= if_rdata_nx;
         dm_rdata_q <= dm_rdata_nx;
      end
   end

   assign bus.mem_sel  = sel_q;
   assign bus.mem_en   = en_q;
   assign bus.mem_we   = we_q;
   assign bus.if_done  = if_done_q;
   assign bus.dm_done  = dm_done_q;
   assign bus.if_rdata = if_rdata_q;
   assign bus.dm_rdata = dm_rdata_q;
endmodule

// File: doc/mem_port_sched.md
# mem_port_sched

Two-requester scheduler for the single shared memory port of the multicycle MIPS core. Instruction fetch (IF) and data access (DM, load/store) both need the one memory; this block grants one requester at a time with round-robin fairness. It drives the select of the existing 32-bit 2:1 address/write-data mux in front of the memory, sequences the fixed-latency access, and returns registered read data with a one-cycle done pulse per requester.

## Interface
- MEM_LAT, 2, cycles from the mem_en cycle to mem_rdata valid; legal range 1..15
- DATA_W, 32, read-data width
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous, active-low
- if_req  in  1  IF request; held high until if_done
- if_rdata  out  DATA_W  IF read data, valid with if_done, held after
- if_done  out  1  one-cycle completion pulse for IF
- dm_req  in  1  DM request; held high until dm_done
- dm_we  in  1  DM write enable; stable while dm_req is high
- dm_rdata  out  DATA_W  DM read data, valid with dm_done on reads
- dm_done  out  1  one-cycle completion pulse for DM
- mem_sel  out  1  address/wdata mux select: 0 = IF, 1 = DM
- mem_en  out  1  memory access strobe, one cycle per access
- mem_we  out  1  memory write strobe, only in the mem_en cycle
- mem_rdata  in  DATA_W  memory read data

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: if any request is high, pick a winner, register mem_sel = winner, load counter = MEM_LAT, go to ACCESS. Otherwise stay.
- Pick rule: only one request high -> that one. Both high -> the port not granted last (last_grant register). last_grant resets to DM, so the first tie goes to IF.
- ACCESS, first cycle: mem_en = 1, mem_we = (winner == DM) & dm_we. Counter decrements each ACCESS cycle. When the counter reaches 0 (mem_rdata valid this cycle), the winner's rdata register captures mem_rdata on reads, last_grant = winner, and the state goes to RESP.
- RESP: the winner's done pulse is 1. The winner's own req is ignored this cycle because it is still high. If the other port requests, it is granted directly and the state goes to ACCESS with no IDLE bubble. Otherwise the state goes to IDLE.
- Writes: no capture. dm_rdata keeps its previous value. dm_done still fires.
- mem_sel stays constant from the ACCESS entry through RESP. In IDLE it holds its last value.
- Requesters keep their address and wdata stable from req until done. The block does not check this.
- A request dropped before done is a protocol violation. The access still completes and done still pulses.

## Timing
- Reset (rst_n low at a clock edge): state IDLE, counter 0, last_grant DM, mem_sel 0. mem_en, mem_we, if_done, dm_done, if_rdata and dm_rdata are all 0.
- Reset mid-ACCESS or mid-RESP aborts the access. No done pulse, and mem_en is 0 from the next cycle.
- Req seen in IDLE in cycle t: mem_en in t+1, mem_rdata sampled in t+1+MEM_LAT, done and rdata in t+2+MEM_LAT.
- Back-to-back accesses alternating through RESP: one access every MEM_LAT+2 cycles.
- A requester granted in RESP or IDLE goes next. A continuously requesting port never waits more than one access.
- Counter width is 4 bits, which covers MEM_LAT ≤ 15.

## Structure
- Shared package mips_mem_pkg holds:
  - the state enum (IDLE, ACCESS, RESP);
  - the PORT_IF = 1'b0 and PORT_DM = 1'b1 constants, reused by the datapath for the mux select.
- One sub-module, mem_rr_pick2: a combinational two-input round-robin pick. Inputs are the two requests, a mask and last_grant; outputs are valid and winner. It is used in both IDLE and RESP.
- Everything else is flat: FSM, counter and the two rdata registers.

## Test plan
All scenarios use MEM_LAT = 2.
- Reset: rst_n low 2 cycles with both reqs high -> all outputs 0 and mem_sel 0 during reset; the first grant after release is IF.
- Single IF read: if_req high at cycle 0, memory model returns 0x21080001 in cycle 3 -> mem_en=1, mem_sel=0 in cycle 1; if_done=1, if_rdata=0x21080001 in cycle 4 only.
- Tie from reset: both reqs high at cycle 0 -> IF gets mem_en in cycle 1 and if_done in cycle 4. DM gets mem_sel=1 and mem_en in cycle 5, and dm_done in cycle 8.
- Sustained contention: both reqs held and re-raised for 6 accesses -> mem_sel per access is 0,1,0,1,0,1; mem_en exactly every 4 cycles.
- DM write: dm_req with dm_we=1, dm_rdata previously 0xDEADBEEF -> mem_we=1 only in the mem_en cycle; dm_done 3 cycles later; dm_rdata still 0xDEADBEEF.
- Reset mid-access: rst_n low in cycle 2 of an IF read -> no if_done, mem_en 0. With both reqs high after release, IF is granted first.
